// File: rtl/alarm_ringer_if.sv
// Alarm ringer bus: time/alarm/user inputs driven by the setter side,
// ring/buzz/snooze status returned by the ringer.
interface alarm_ringer_if;
   logic       tick_1s;
   logic [5:0] cur_hr;
   logic [5:0] cur_min;
   logic [5:0] cur_sec;
   logic [5:0] alm_hr;
   logic [5:0] alm_min;
   logic       almen;
   logic       stop;
   logic       snooze;
   logic       ringing;
   logic       buzz;
   logic       snz_act;
   logic [5:0] snz_hr;
   logic [5:0] snz_min;
   logic [1:0] snz_cnt;

   modport master (
      output tick_1s, cur_hr, cur_min, cur_sec, alm_hr, alm_min, almen, stop, snooze,
      input  ringing, buzz, snz_act, snz_hr, snz_min, snz_cnt
   );

   modport slave (
      input  tick_1s, cur_hr, cur_min, cur_sec, alm_hr, alm_min, almen, stop, snooze,
      output ringing, buzz, snz_act, snz_hr, snz_min, snz_cnt
   );
endinterface

// File: rtl/alarm_ringer.sv
// Alarm ringer: rings at the alarm minute, drives a 1 Hz beep, and handles
// stop, bounded snooze and unattended-ring timeout.
module alarm_ringer #(
   parameter int SNOOZE_MIN = 5,
   parameter int MAX_SNOOZE = 3,
   parameter int RING_TO_S  = 60
) (
   input  logic           clk,
   input  logic           rst,
   alarm_ringer_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_RING, S_SNOOZE, S_DONE} state_t;

   localparam logic [7:0] TO_LAST = 8'(RING_TO_S - 1);

   state_t     r_state;
   state_t     w_state_nxt;
   logic       w_enter_ring;
   logic       w_take_snz;

   logic [5:0] r_ring_min;
   logic [7:0] r_to_cnt;
   logic       r_ringing;
   logic       r_buzz;
   logic       r_snz_act;
   logic [5:0] r_snz_hr;
   logic [5:0] r_snz_min;
   logic [1:0] r_snz_cnt;

   logic       w_alm_valid;
   logic [5:0] w_tgt_hr;
   logic [5:0] w_tgt_min;
   logic       w_match;
   logic [6:0] w_min_sum;
   logic       w_min_wrap;
   logic [5:0] w_snz_hr_nxt;
   logic [5:0] w_snz_min_nxt;
   logic       w_snz_ok;
   logic       w_to_hit;

   // Snooze target is always a legal time; only the programmed alarm needs range checking.
   assign w_alm_valid = (bus.alm_hr <= 6'd23) && (bus.alm_min <= 6'd59);
   assign w_tgt_hr    = (r_state == S_SNOOZE) ? r_snz_hr  : bus.alm_hr;
   assign w_tgt_min   = (r_state == S_SNOOZE) ? r_snz_min : bus.alm_min;
   assign w_match     = (bus.cur_sec == 6'd0) && (bus.cur_hr == w_tgt_hr) &&
                        (bus.cur_min == w_tgt_min) && ((r_state == S_SNOOZE) || w_alm_valid);

   assign w_min_sum     = {1'b0, bus.cur_min} + 7'(SNOOZE_MIN);
   assign w_min_wrap    = (w_min_sum >= 7'd60);
   assign w_snz_min_nxt = w_min_wrap ? 6'(w_min_sum - 7'd60) : w_min_sum[5:0];
   assign w_snz_hr_nxt  = !w_min_wrap ? bus.cur_hr :
                          (bus.cur_hr >= 6'd23) ? 6'd0 : bus.cur_hr + 6'd1;

   assign w_snz_ok = (r_snz_cnt < 2'(MAX_SNOOZE));
   assign w_to_hit = bus.tick_1s && (r_to_cnt == TO_LAST);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt  = r_state;
      w_enter_ring = 1'b0;
      w_take_snz   = 1'b0;
      if (!bus.almen) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_match) begin
                  w_state_nxt  = S_RING;
                  w_enter_ring = 1'b1;
               end
            end
            S_RING: begin
               if (bus.stop) begin
                  w_state_nxt = S_DONE;
               end else if (bus.snooze) begin
                  if (w_snz_ok) begin
                     w_state_nxt = S_SNOOZE;
                     w_take_snz  = 1'b1;
                  end else begin
                     w_state_nxt = S_DONE;
                  end
               end else if (w_to_hit) begin
                  w_state_nxt = S_DONE;
               end
            end
            S_SNOOZE: begin
               if (bus.stop) begin
                  w_state_nxt = S_DONE;
               end else if (w_match) begin
                  w_state_nxt  = S_RING;
                  w_enter_ring = 1'b1;
               end
            end
            S_DONE: begin
               // Holding here for the rest of the alarm minute prevents an immediate re-trigger.
               if (bus.cur_min != r_ring_min) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ring_min <= 6'd0;
         r_to_cnt   <= 8'd0;
         r_ringing  <= 1'b0;
         r_buzz     <= 1'b0;
         r_snz_act  <= 1'b0;
         r_snz_hr   <= 6'd0;
         r_snz_min  <= 6'd0;
         r_snz_cnt  <= 2'd0;
      end else begin
         r_ringing <= (w_state_nxt == S_RING);
         r_snz_act <= (w_state_nxt == S_SNOOZE);

         if (w_enter_ring) begin
            r_ring_min <= bus.cur_min;
            r_to_cnt   <= 8'd0;
         end else if ((r_state == S_RING) && bus.tick_1s) begin
            r_to_cnt <= r_to_cnt + 8'd1;
         end

         if (w_state_nxt != S_RING) r_buzz <= 1'b0;
         else if (w_enter_ring)     r_buzz <= 1'b1;
         else if (bus.tick_1s)      r_buzz <= ~r_buzz;

         if (w_take_snz) begin
            r_snz_hr  <= w_snz_hr_nxt;
            r_snz_min <= w_snz_min_nxt;
            r_snz_cnt <= r_snz_cnt + 2'd1;
         end else if (w_state_nxt == S_IDLE) begin
            r_snz_cnt <= 2'd0;
         end
      end
   end

   assign bus.ringing = r_ringing;
   assign bus.buzz    = r_buzz;
   assign bus.snz_act = r_snz_act;
   assign bus.snz_hr  = r_snz_hr;
   assign bus.snz_min = r_snz_min;
   assign bus.snz_cnt = r_snz_cnt;

endmodule
